// File: rtl/pdm_top.sv
// pdm_top: PDM microphone record/playback block.
// Generates the microphone clock and turns the PDM bitstream into 7-bit
// amplitude samples (ones counted over 128-bit windows). BTNU records samples
// into on-chip RAM, BTNC plays them back through an open-drain PWM output.
// Optional build macro PDM_PASSTHRU_EN: while idle, the live microphone level
// drives the PWM output and the amplifier is enabled (monitor mode).
module pdm_top #(
  parameter int CLK_FREQ  = 100,
  parameter int RAM_DEPTH = 131072
) (
  input  logic        clk,
  input  logic        rst,
  output logic        m_clk,
  output logic        m_lr_sel,
  input  logic        m_data,
  input  logic        BTNU,
  input  logic        BTNC,
  output logic [15:0] LED,
  output logic        R,
  output logic        G,
  output logic        B,
  output wire         AUD_PWM,
  output logic        AUD_SD
);

  localparam int HALF = CLK_FREQ / 5;
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int AW   = $clog2(RAM_DEPTH);
  localparam int LW   = AW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [DW-1:0]   div_cnt;
  logic            strobe;
  logic            m_data_s1;
  logic            m_data_s2;
  logic            btnu_s1;
  logic            btnu_s2;
  logic            btnu_s3;
  logic            btnc_s1;
  logic            btnc_s2;
  logic            btnc_s3;
  logic            btnu_edge;
  logic            btnc_edge;
  logic [6:0]      bit_cnt;
  logic [7:0]      ones;
  logic [6:0]      sample;
  logic            sample_valid;
  logic [15:0]     led_d;
  logic [AW-1:0]   waddr;
  logic [AW-1:0]   waddr_d;
  logic [AW-1:0]   raddr;
  logic [AW-1:0]   raddr_d;
  logic [LW-1:0]   rec_len;
  logic [LW-1:0]   rec_len_d;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [6:0]      ram [RAM_DEPTH];
  logic [6:0]      ram_q;
  logic [6:0]      pwm_cnt;
  logic [6:0]      pwm_src;
  logic            sd_on;

  assign m_lr_sel  = 1'b0;
  assign btnu_edge = btnu_s2 & ~btnu_s3;
  assign btnc_edge = btnc_s2 & ~btnc_s3;

  // Microphone clock divider; strobe marks the clk edge where m_clk rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      m_clk   <= 1'b0;
      strobe  <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (div_cnt == DW'(HALF - 1)) begin
        div_cnt <= '0;
        m_clk   <= ~m_clk;
        strobe  <= ~m_clk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Two-flop synchronisers for the asynchronous inputs, plus a third stage on the buttons for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data_s1 <= 1'b0;
      m_data_s2 <= 1'b0;
      btnu_s1   <= 1'b0;
      btnu_s2   <= 1'b0;
      btnu_s3   <= 1'b0;
      btnc_s1   <= 1'b0;
      btnc_s2   <= 1'b0;
      btnc_s3   <= 1'b0;
    end else begin
      m_data_s1 <= m_data;
      m_data_s2 <= m_data_s1;
      btnu_s1   <= BTNU;
      btnu_s2   <= btnu_s1;
      btnu_s3   <= btnu_s2;
      btnc_s1   <= BTNC;
      btnc_s2   <= btnc_s1;
      btnc_s3   <= btnc_s2;
    end
  end

  // Count ones over 128 m_clk bits; the bit arriving on the closing strobe starts the next window.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt      <= '0;
      ones         <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (strobe) begin
        bit_cnt <= bit_cnt + 7'd1;
        if (bit_cnt == 7'd127) begin
          sample       <= (ones > 8'd127) ? 7'd127 : ones[6:0];
          sample_valid <= 1'b1;
          ones         <= {7'b0, m_data_s2};
        end else begin
          ones <= ones + {7'b0, m_data_s2};
        end
      end
    end
  end

  // Thermometer code of the top four sample bits; LED[15] can never light.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < 15; i++) begin
      led_d[i] = (4'(i) < sample[6:3]);
    end
  end

  // Level meter only moves when a new sample is ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      LED <= '0;
    end else if (sample_valid) begin
      LED <= led_d;
    end
  end

  // State and address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      waddr   <= '0;
      raddr   <= '0;
      rec_len <= '0;
    end else begin
      state   <= state_d;
      waddr   <= waddr_d;
      raddr   <= raddr_d;
      rec_len <= rec_len_d;
    end
  end

  // Record/play sequencing; record wins when both buttons hit together in IDLE.
  always_comb begin
    state_d   = state;
    waddr_d   = waddr;
    raddr_d   = raddr;
    rec_len_d = rec_len;
    ram_we    = 1'b0;
    case (state)
      IDLE: begin
        if (btnu_edge) begin
          state_d = RECORD;
          waddr_d = '0;
        end else if (btnc_edge && (rec_len != '0)) begin
          state_d = PLAY;
          raddr_d = '0;
        end
      end
      RECORD: begin
        if (sample_valid) begin
          ram_we  = 1'b1;
          waddr_d = waddr + 1'b1;
        end
        if (btnu_edge || (sample_valid && (waddr == AW'(RAM_DEPTH - 1)))) begin
          rec_len_d = {1'b0, waddr} + LW'(sample_valid);
          state_d   = IDLE;
        end
      end
      PLAY: begin
        if (btnc_edge) begin
          state_d = IDLE;
        end else if (sample_valid) begin
          if (({1'b0, raddr} + 1'b1) == rec_len) begin
            state_d = IDLE;
          end else begin
            raddr_d = raddr + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_addr = (state == RECORD) ? waddr : raddr;

  // Single-port sample RAM with one cycle of read latency; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr] <= sample;
    end
    ram_q <= ram[ram_addr];
  end

  // Free-running PWM ramp; any 128 consecutive cycles see every count once.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 7'd1;
    end
  end

  // Select what the amplifier hears; silent unless playing (or monitoring while idle).
  always_comb begin
    pwm_src = 7'd0;
    sd_on   = 1'b0;
    if (state == PLAY) begin
      pwm_src = ram_q;
      sd_on   = 1'b1;
    end
`ifdef PDM_PASSTHRU_EN
    else if (state == IDLE) begin
      pwm_src = sample;
      sd_on   = 1'b1;
    end
`else
    else begin
      pwm_src = 7'd0;
      sd_on   = 1'b0;
    end
`endif
  end

  assign AUD_SD  = sd_on;
  assign AUD_PWM = (pwm_cnt < pwm_src) ? 1'bz : 1'b0;

  assign R = (state == RECORD);
  assign G = (state == PLAY);
  assign B = (state == IDLE);

endmodule

// File: tb/tb_pdm_top.sv
// tb_pdm_top: directed bench for pdm_top with a first-order sigma-delta
// microphone model. A scaled-down divider and RAM keep run time short.
module tb_pdm_top;

  localparam int CLK_FREQ  = 5;
  localparam int HALF      = CLK_FREQ / 5;
  localparam int RAM_DEPTH = 64;
  localparam int SP        = 256 * HALF;
`ifdef PDM_PASSTHRU_EN
  localparam logic IDLE_SD = 1'b1;
`else
  localparam logic IDLE_SD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m_data;
  logic        BTNU;
  logic        BTNC;
  wire         m_clk;
  wire         m_lr_sel;
  wire  [15:0] LED;
  wire         R;
  wire         G;
  wire         B;
  wire         AUD_PWM;
  wire         AUD_SD;

  int total = 0;
  int bad   = 0;
  int sd_level = 0;
  int sd_acc   = 0;
  int sd_sum   = 0;

  pullup (AUD_PWM);

  pdm_top #(
    .CLK_FREQ (CLK_FREQ),
    .RAM_DEPTH(RAM_DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_clk   (m_clk),
    .m_lr_sel(m_lr_sel),
    .m_data  (m_data),
    .BTNU    (BTNU),
    .BTNC    (BTNC),
    .LED     (LED),
    .R       (R),
    .G       (G),
    .B       (B),
    .AUD_PWM (AUD_PWM),
    .AUD_SD  (AUD_SD)
  );

  // System clock.
  initial begin
    forever #5 clk = ~clk;
  end

  // Sigma-delta microphone: sd_level/128 ones density, one bit per m_clk period.
  initial begin
    m_data = 1'b0;
    forever begin
      @(negedge m_clk);
      #1;
      sd_sum = sd_acc + sd_level;
      m_data = (sd_sum >= 128);
      sd_acc = sd_sum % 128;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    BTNU = 1'b0;
    BTNC = 1'b0;
    wait_clk(3);
    total++; if (m_clk !== 1'b0) begin bad++; $display("[TB] FAIL reset_m_clk got=%b exp=0", m_clk); end
    total++; if (LED !== 16'h0000) begin bad++; $display("[TB] FAIL reset_led got=%h exp=0000", LED); end
    total++; if ({R, G, B} !== 3'b001) begin bad++; $display("[TB] FAIL reset_rgb got=%b exp=001", {R, G, B}); end
    total++; if (AUD_SD !== IDLE_SD) begin bad++; $display("[TB] FAIL reset_aud_sd got=%b exp=%b", AUD_SD, IDLE_SD); end
    total++; if (AUD_PWM !== 1'b0) begin bad++; $display("[TB] FAIL reset_aud_pwm got=%b exp=0", AUD_PWM); end
    rst = 1'b0;
  endtask

  task automatic test_mclk;
    int high_cnt = 0;
    int run = 0;
    int bad_run = 0;
    int lr_bad = 0;
    int idle_bad = 0;
    int first_rise = -1;
    int period = -1;
    logic seen = 1'b0;
    logic prev;
    prev = m_clk;
    for (int i = 0; i < 200; i++) begin
      wait_clk(1);
      if (m_clk === 1'b1) high_cnt++;
      if (m_lr_sel !== 1'b0) lr_bad++;
      if (AUD_SD !== IDLE_SD) idle_bad++;
`ifndef PDM_PASSTHRU_EN
      if (AUD_PWM !== 1'b0) idle_bad++;
`endif
      if (m_clk !== prev) begin
        if (seen && (run != HALF)) bad_run++;
        seen = 1'b1;
        run  = 1;
        if (m_clk === 1'b1) begin
          if (first_rise < 0) first_rise = i;
          else if (period < 0) period = i - first_rise;
        end
      end else begin
        run++;
      end
      prev = m_clk;
    end
    total++; if (period != 2 * HALF) begin bad++; $display("[TB] FAIL mclk_period got=%0d exp=%0d", period, 2 * HALF); end
    total++; if (high_cnt != 100) begin bad++; $display("[TB] FAIL mclk_high_cycles got=%0d exp=100", high_cnt); end
    total++; if (bad_run != 0) begin bad++; $display("[TB] FAIL mclk_duty bad_runs=%0d exp=0", bad_run); end
    total++; if (lr_bad != 0) begin bad++; $display("[TB] FAIL lr_sel_tied got=%0d nonzero cycles exp=0", lr_bad); end
    total++; if (idle_bad != 0) begin bad++; $display("[TB] FAIL idle_audio got=%0d bad cycles exp=0", idle_bad); end
  endtask

  task automatic test_play_empty;
    int g_seen = 0;
    BTNC = 1'b1;
    for (int i = 0; i < 24; i++) begin
      wait_clk(1);
      if (i == 3) BTNC = 1'b0;
      if (G !== 1'b0) g_seen++;
    end
    total++; if (g_seen != 0) begin bad++; $display("[TB] FAIL play_empty_g got=%0d G cycles exp=0", g_seen); end
    total++; if (B !== 1'b1) begin bad++; $display("[TB] FAIL play_empty_b got=%b exp=1", B); end
    total++; if (AUD_SD !== IDLE_SD) begin bad++; $display("[TB] FAIL play_empty_sd got=%b exp=%b", AUD_SD, IDLE_SD); end
  endtask

  task automatic test_levels;
    int          lv  [5];
    logic [15:0] exp [5];
    lv  = '{128, 0, 64, 100, 24};
    exp = '{16'h7FFF, 16'h0000, 16'h00FF, 16'h0FFF, 16'h0007};
    for (int k = 0; k < 5; k++) begin
      sd_level = lv[k];
      wait_clk(3 * SP);
      total++;
      if (LED !== exp[k]) begin
        bad++;
        $display("[TB] FAIL level_led_%0d got=%h exp=%h", lv[k], LED, exp[k]);
      end
    end
  endtask

  task automatic test_record_play;
    int lv [8];
    int duties [$];
    int r_drop = 0;
    int g_cnt = 0;
    int cyc = 0;
    int blk_cnt = 0;
    int blk_hi = 0;
    int sd_bad = 0;
    int pwm_bad = 0;
    int idx = 0;
    logic found;
    lv = '{64, 100, 124, 100, 64, 28, 4, 28};
    sd_level = 64;
    wait_clk(2 * SP);
    BTNU = 1'b1;
    sd_level = lv[0];
    wait_clk(4);
    BTNU = 1'b0;
    total++; if ({R, G, B} !== 3'b100) begin bad++; $display("[TB] FAIL record_enter rgb got=%b exp=100", {R, G, B}); end
    wait_clk(5 * SP - 4);
    for (int k = 1; k < 8; k++) begin
      sd_level = lv[k];
      for (int j = 0; j < 5 * SP; j++) begin
        wait_clk(1);
        if (R !== 1'b1) r_drop++;
      end
    end
    BTNU = 1'b1;
    wait_clk(4);
    BTNU = 1'b0;
    wait_clk(2);
    total++; if (r_drop != 0) begin bad++; $display("[TB] FAIL record_hold got=%0d cycles without R exp=0", r_drop); end
    total++; if ({R, G, B} !== 3'b001) begin bad++; $display("[TB] FAIL record_exit rgb got=%b exp=001", {R, G, B}); end

    BTNC = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_clk(1);
      if (i == 3) BTNC = 1'b0;
      if (G === 1'b1) g_cnt++;
    end
    while ((G === 1'b1) && (cyc < 42 * SP)) begin
      if (cyc == 10 * SP) BTNU = 1'b1;
      if (cyc == 10 * SP + 4) BTNU = 1'b0;
      if (AUD_SD !== 1'b1) sd_bad++;
      if (AUD_PWM === 1'b1) blk_hi++;
      else if (AUD_PWM !== 1'b0) pwm_bad++;
      blk_cnt++;
      if (blk_cnt == 128) begin
        duties.push_back(blk_hi);
        blk_cnt = 0;
        blk_hi  = 0;
      end
      wait_clk(1);
      cyc++;
      if (G === 1'b1) g_cnt++;
    end
    total++;
    if ((g_cnt <= 39 * SP) || (g_cnt > 40 * SP)) begin
      bad++;
      $display("[TB] FAIL play_length got=%0d cycles exp=%0d..%0d", g_cnt, 39 * SP + 1, 40 * SP);
    end
    total++; if (sd_bad != 0) begin bad++; $display("[TB] FAIL play_aud_sd got=%0d low cycles exp=0", sd_bad); end
    total++; if (pwm_bad != 0) begin bad++; $display("[TB] FAIL play_pwm_level got=%0d bad cycles exp=0", pwm_bad); end
    for (int k = 0; k < 8; k++) begin
      found = 1'b0;
      while ((idx < duties.size()) && !found) begin
        if (duties[idx] == lv[k]) found = 1'b1;
        idx++;
      end
      total++;
      if (!found) begin
        bad++;
        $display("[TB] FAIL play_duty_step%0d got=not found exp=%0d/128", k, lv[k]);
      end
    end
    wait_clk(2);
    total++; if ({R, G, B} !== 3'b001) begin bad++; $display("[TB] FAIL play_end rgb got=%b exp=001", {R, G, B}); end
    total++; if (AUD_SD !== IDLE_SD) begin bad++; $display("[TB] FAIL play_end_sd got=%b exp=%b", AUD_SD, IDLE_SD); end
  endtask

  task automatic test_reset_mid_record;
    int g_seen = 0;
    BTNU = 1'b1;
    BTNC = 1'b1;
    wait_clk(4);
    BTNU = 1'b0;
    BTNC = 1'b0;
    total++; if ({R, G, B} !== 3'b100) begin bad++; $display("[TB] FAIL both_buttons rgb got=%b exp=100", {R, G, B}); end
    wait_clk(3 * SP);
    rst = 1'b1;
    wait_clk(1);
    total++; if ({R, G, B} !== 3'b001) begin bad++; $display("[TB] FAIL mid_reset rgb got=%b exp=001", {R, G, B}); end
    rst = 1'b0;
    BTNC = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_clk(1);
      if (i == 3) BTNC = 1'b0;
      if (G !== 1'b0) g_seen++;
    end
    total++; if (g_seen != 0) begin bad++; $display("[TB] FAIL play_after_reset got=%0d G cycles exp=0", g_seen); end
    total++; if (AUD_SD !== IDLE_SD) begin bad++; $display("[TB] FAIL after_reset_sd got=%b exp=%b", AUD_SD, IDLE_SD); end
  endtask

  task automatic test_full_depth;
    int r_cnt = 0;
    int g_bad = 0;
    int g_drop = 0;
    int cyc = 0;
    sd_level = 64;
    BTNU = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_clk(1);
      if (i == 3) BTNU = 1'b0;
      if (R === 1'b1) r_cnt++;
    end
    while ((R === 1'b1) && (cyc < 70 * SP)) begin
      if (cyc == 20 * SP) BTNC = 1'b1;
      if (cyc == 20 * SP + 4) BTNC = 1'b0;
      if (G !== 1'b0) g_bad++;
      wait_clk(1);
      cyc++;
      if (R === 1'b1) r_cnt++;
    end
    total++;
    if ((r_cnt <= (RAM_DEPTH - 1) * SP) || (r_cnt > RAM_DEPTH * SP)) begin
      bad++;
      $display("[TB] FAIL full_record_length got=%0d cycles exp=%0d..%0d", r_cnt, (RAM_DEPTH - 1) * SP + 1, RAM_DEPTH * SP);
    end
    total++; if (g_bad != 0) begin bad++; $display("[TB] FAIL btnc_ignored_in_record got=%0d G cycles exp=0", g_bad); end
    total++; if (B !== 1'b1) begin bad++; $display("[TB] FAIL full_record_idle got=%b exp=1", B); end

    BTNC = 1'b1;
    wait_clk(4);
    BTNC = 1'b0;
    for (int i = 0; i < 50 * SP; i++) begin
      wait_clk(1);
      if (G !== 1'b1) g_drop++;
    end
    total++; if (g_drop != 0) begin bad++; $display("[TB] FAIL full_play_running got=%0d idle cycles exp=0", g_drop); end
    BTNC = 1'b1;
    wait_clk(4);
    BTNC = 1'b0;
    wait_clk(1);
    total++; if ({R, G, B} !== 3'b001) begin bad++; $display("[TB] FAIL btnc_stop rgb got=%b exp=001", {R, G, B}); end
    total++; if (AUD_SD !== IDLE_SD) begin bad++; $display("[TB] FAIL btnc_stop_sd got=%b exp=%b", AUD_SD, IDLE_SD); end
  endtask

  // Scenario sequence.
  initial begin
    rst  = 1'b1;
    BTNU = 1'b0;
    BTNC = 1'b0;
    test_reset();
    test_mclk();
    test_play_empty();
    test_levels();
    test_record_play();
    test_reset_mid_record();
    test_full_depth();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
